// File: rtl/uart_string_arbiter.sv
// uart_string_arbiter
//
// Shares one framed-string UART transmitter between NUM_REQ requesters.
// A round-robin pick latches the winner's payload/length, issues a single
// tx_req pulse, then follows the engine's tx_busy/tx_done handshake with a
// start timeout and a frame timeout. Each frame ends with a one-cycle
// req_done or req_err pulse on the winner's bit.
//
// Ports
//   sys_clk, sys_rst       : clock, synchronous active-high reset
//   req        [NUM_REQ]   : level request, held until req_done/req_err
//   req_string [NUM_REQ*STR_W], req_length [NUM_REQ*LEN_W] : per-requester data
//   grant      [NUM_REQ]   : one-hot, selection through completion cycle
//   req_done / req_err     : one-cycle per-requester completion pulses
//   tx_string, tx_length   : latched payload/length to the engine
//   tx_req                 : one-cycle frame start pulse
//   tx_busy, tx_done       : engine status (busy level, done pulse)
//   arb_busy               : high whenever the FSM is not IDLE
//   arb_state              : current FSM state, for observation
//
// Handshake: a requester raises req and keeps it (and its data) stable until
// grant rises; after that its data may change, and the transaction always
// finishes with exactly one req_done or req_err pulse on its bit, whether or
// not req is still high.

module uart_string_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int STR_W         = 1096,
    parameter int LEN_W         = 8,
    parameter int START_TIMEOUT = 16,
    parameter int FRAME_TIMEOUT = 2_000_000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*STR_W-1:0] req_string,
    input  logic [NUM_REQ*LEN_W-1:0] req_length,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       req_done,
    output logic [NUM_REQ-1:0]       req_err,
    output logic [STR_W-1:0]         tx_string,
    output logic [LEN_W-1:0]         tx_length,
    output logic                     tx_req,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic                     arb_busy,
    output logic [2:0]               arb_state
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ARB       = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;
    localparam logic [2:0] S_FAIL      = 3'd6;

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (FRAME_TIMEOUT > START_TIMEOUT) ? FRAME_TIMEOUT : START_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Terminal counts: the timeout fires on the cycle the counter steps onto
    // TIMEOUT-1, so WAIT_BUSY lasts at most START_TIMEOUT-1 cycles.
    localparam logic [CNT_W-1:0] START_TERM = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FRAME_TERM = CNT_W'(FRAME_TIMEOUT - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [IDX_W-1:0] last;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [STR_W-1:0] win_string;
    logic [LEN_W-1:0] win_length;
    int               cand;

    assign arb_state = state;
    assign cnt_inc   = cnt + CNT_W'(1);

    // Round-robin search starting just after the last winner, wrapping, so
    // the requester served most recently is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    assign win_string = req_string[int'(win_idx)*STR_W +: STR_W];
    assign win_length = req_length[int'(win_idx)*LEN_W +: LEN_W];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (|req) state_nxt = S_ARB;
            S_ARB: begin
                if (!win_found)            state_nxt = S_IDLE;
                else if (win_length == '0) state_nxt = S_FAIL;
                else                       state_nxt = S_ISSUE;
            end
            S_ISSUE:     state_nxt = S_WAIT_BUSY;
            // Busy wins over a coincident done; a done that is not still
            // high next cycle is lost and the frame times out.
            S_WAIT_BUSY: begin
                if (tx_busy)                   state_nxt = S_WAIT_DONE;
                else if (cnt_inc == START_TERM) state_nxt = S_FAIL;
            end
            // Done wins over a coincident terminal count.
            S_WAIT_DONE: begin
                if (tx_done)                   state_nxt = S_DONE;
                else if (cnt_inc == FRAME_TERM) state_nxt = S_FAIL;
            end
            S_DONE:      state_nxt = S_IDLE;
            S_FAIL:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            last      <= IDX_W'(NUM_REQ - 1);
            cnt       <= '0;
            grant     <= '0;
            req_done  <= '0;
            req_err   <= '0;
            tx_string <= '0;
            tx_length <= '0;
            tx_req    <= 1'b0;
            arb_busy  <= 1'b0;
        end else begin
            state    <= state_nxt;
            arb_busy <= (state_nxt != S_IDLE);
            tx_req   <= 1'b0;
            req_done <= '0;
            req_err  <= '0;
            case (state)
                S_ARB: begin
                    if (win_found) begin
                        grant     <= NUM_REQ'(1) << win_idx;
                        tx_string <= win_string;
                        tx_length <= win_length;
                        last      <= win_idx;
                        tx_req    <= (win_length != '0);
                    end
                end
                S_ISSUE:     cnt <= '0;
                S_WAIT_BUSY: cnt <= tx_busy ? '0 : cnt_inc;
                S_WAIT_DONE: cnt <= cnt_inc;
                S_DONE: begin
                    req_done <= grant;
                    grant    <= '0;
                end
                S_FAIL: begin
                    req_err <= grant;
                    grant   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
